// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the shared-ALU arbiter.
// ALU opcodes, slot states and the requester index width helper.
package alu_share_arbiter_pkg;

    localparam int ALU_OP_W = 4;
    localparam int XLEN     = 32;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLL  = 4'h2,
        ALU_SLT  = 4'h3,
        ALU_SLTU = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_OR   = 4'h8,
        ALU_AND  = 4'h9
    } alu_op_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between issuers and the shared ALU.
// master = issuer side, slave = arbiter side.
interface alu_share_arbiter_if
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4,
    parameter int ID_W    = 1
);

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [ALU_OP_W*NUM_REQ-1:0] req_op;
    logic [XLEN*NUM_REQ-1:0]     req_a;
    logic [XLEN*NUM_REQ-1:0]     req_b;
    logic [TAG_W*NUM_REQ-1:0]    req_tag;

    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [ID_W-1:0]             rsp_id;
    logic [TAG_W-1:0]            rsp_tag;
    logic [XLEN-1:0]             rsp_result;
    logic                        rsp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag,
        input  rsp_ready,
        output req_ready,
        output rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_zero
    );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit integer ALU.
// Unknown opcodes yield result 0, which also raises zero.
module alu
    import alu_share_arbiter_pkg::*;
(
    input  logic [ALU_OP_W-1:0] op,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic [XLEN-1:0]     result,
    output logic                zero
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;

    assign shamt = b[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    // opcode decode
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin grant: first valid request at or above ptr,
// otherwise wrap to the lowest valid request.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    logic [NUM_REQ-1:0] hi;
    logic [NUM_REQ-1:0] pick;

    // mask off requests below the pointer, pick lowest survivor
    always_comb begin
        hi = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi[i] = req[i] && (ID_W'(i) >= ptr);
        end
        pick = (|hi) ? hi : req;
        gnt  = '0;
        idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pick[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = ID_W'(i);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ issuers with round-robin grant
// and a single registered, tagged response slot.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus
);

    slot_state_e         state;
    slot_state_e         state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     rr_ptr_nxt;
    logic [ID_W-1:0]     gnt_idx;
    logic [NUM_REQ-1:0]  gnt;
    logic                gnt_any;
    logic                can_accept;
    logic                xfer;

    logic [ALU_OP_W-1:0] alu_op;
    logic [XLEN-1:0]     alu_a;
    logic [XLEN-1:0]     alu_b;
    logic [XLEN-1:0]     alu_res;
    logic                alu_zero;
    logic [TAG_W-1:0]    sel_tag;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // slot can take a new op when empty or being drained this cycle
    assign can_accept    = rst_n && ((state == SLOT_EMPTY) || bus.rsp_ready);
    assign xfer          = can_accept && gnt_any;
    assign bus.req_ready = can_accept ? gnt : '0;

    // steer the granted requester's payload onto the ALU
    always_comb begin
        alu_op  = '0;
        alu_a   = '0;
        alu_b   = '0;
        sel_tag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                alu_op  = bus.req_op[i*ALU_OP_W +: ALU_OP_W];
                alu_a   = bus.req_a[i*XLEN +: XLEN];
                alu_b   = bus.req_b[i*XLEN +: XLEN];
                sel_tag = bus.req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    alu u_alu (
        .op     (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_res),
        .zero   (alu_zero)
    );

    // slot state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SLOT_EMPTY;
        else        state <= state_nxt;
    end

    // slot next state: fill on transfer, empty on drain without refill
    always_comb begin
        state_nxt = state;
        unique case (state)
            SLOT_EMPTY: if (xfer) state_nxt = SLOT_FULL;
            SLOT_FULL:  if (bus.rsp_ready && !xfer) state_nxt = SLOT_EMPTY;
        endcase
    end

    assign bus.rsp_valid = (state == SLOT_FULL);

    // response payload, loaded only on a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_id     <= '0;
            bus.rsp_tag    <= '0;
            bus.rsp_result <= '0;
            bus.rsp_zero   <= 1'b0;
        end else if (xfer) begin
            bus.rsp_id     <= gnt_idx;
            bus.rsp_tag    <= sel_tag;
            bus.rsp_result <= alu_res;
            bus.rsp_zero   <= alu_zero;
        end
    end

    assign rr_ptr_nxt = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                        : gnt_idx + 1'b1;

    // round-robin pointer advances past each winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rr_ptr <= '0;
        else if (xfer) rr_ptr <= rr_ptr_nxt;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: op table, scoreboarded responses,
// plus reset, contention, backpressure and fairness sequences.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int NR = 2;
    localparam int TW = 4;
    localparam int IW = 1;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        string       nm;
    } vec_t;

    typedef struct {
        int          id;
        logic [3:0]  tag;
        logic [31:0] res;
        logic        zero;
        string       nm;
    } exp_t;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t        sb_q[$];
    logic [31:0] pend_res[NR];
    logic        pend_zero[NR];
    string       pend_nm[NR];
    vec_t        vecs[12];

    alu_share_arbiter_if #(.NUM_REQ(NR), .TAG_W(TW), .ID_W(IW)) bus ();

    alu_share_arbiter #(.NUM_REQ(NR), .TAG_W(TW), .ID_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    task automatic set_req(input int i, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag, input logic [31:0] res,
                           input logic z, input string nm);
        bus.req_op[i*4 +: 4]   = op;
        bus.req_a[i*32 +: 32]  = a;
        bus.req_b[i*32 +: 32]  = b;
        bus.req_tag[i*4 +: 4]  = tag;
        pend_res[i]  = res;
        pend_zero[i] = z;
        pend_nm[i]   = nm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: pop on response handshake, push on request handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: got response id=%0d, want none",
                             bus.rsp_id);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check({"rsp_id ", e.nm}, 32'(bus.rsp_id), 32'(e.id));
                    check({"rsp_tag ", e.nm}, 32'(bus.rsp_tag), 32'(e.tag));
                    check({"rsp_result ", e.nm}, bus.rsp_result, e.res);
                    check({"rsp_zero ", e.nm}, 32'(bus.rsp_zero), 32'(e.zero));
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    sb_q.push_back('{id: i, tag: bus.req_tag[i*4 +: 4],
                                     res: pend_res[i], zero: pend_zero[i],
                                     nm: pend_nm[i]});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  exp_g;
        logic [31:0] ca;
        logic [31:0] cb;

        vecs[0]  = '{ALU_SUB,  32'd3,         32'd3,         32'h0,         1'b1, "sub_zero"};
        vecs[1]  = '{ALU_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, "sra"};
        vecs[2]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, "slt"};
        vecs[3]  = '{ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, "sltu"};
        vecs[4]  = '{4'hF,     32'd12,        32'd34,        32'd0,         1'b1, "bad_op"};
        vecs[5]  = '{ALU_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, "add_wrap"};
        vecs[6]  = '{ALU_SLL,  32'd1,         32'd31,        32'h8000_0000, 1'b0, "sll"};
        vecs[7]  = '{ALU_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, "srl"};
        vecs[8]  = '{ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, "xor"};
        vecs[9]  = '{ALU_OR,   32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, "or"};
        vecs[10] = '{ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, "and"};
        vecs[11] = '{ALU_SLL,  32'd3,         32'd33,        32'd6,         1'b0, "sll_mask"};

        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 4'h0, 0, 0, 0, 0, 1'b1, "idle");

        // reset state, requests held off while in reset
        tick();
        bus.req_valid = 2'b11;
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_result", bus.rsp_result, 32'h0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
        check("rst_rsp_tag", 32'(bus.rsp_tag), 32'h0);
        check("rst_rsp_zero", 32'(bus.rsp_zero), 32'h0);
        bus.req_valid = '0;
        tick();
        rst_n = 1'b1;

        // single op
        set_req(0, ALU_ADD, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0, "single_add");
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("single_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        check("single_valid", 32'(bus.rsp_valid), 32'h1);
        check("single_result", bus.rsp_result, 32'd12);
        check("single_tag", 32'(bus.rsp_tag), 32'd3);
        tick();
        @(negedge clk);
        check("single_empty", 32'(bus.rsp_valid), 32'h0);

        // reset while the slot is full and stalled
        set_req(0, ALU_ADD, 32'd1, 32'd2, 4'd9, 32'd3, 1'b0, "pre_reset");
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        check("prerst_full", 32'(bus.rsp_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.rsp_valid), 32'h0);
        check("midrst_result", bus.rsp_result, 32'h0);
        check("midrst_tag", 32'(bus.rsp_tag), 32'h0);
        check("midrst_id", 32'(bus.rsp_id), 32'h0);
        check("midrst_zero", 32'(bus.rsp_zero), 32'h0);
        sb_q.delete();
        set_req(0, ALU_ADD, 32'd10, 32'd1, 4'd1, 32'd11, 1'b0, "cont");
        set_req(1, ALU_ADD, 32'd20, 32'd2, 4'd2, 32'd22, 1'b0, "cont");
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b1;
        #1;
        check("midrst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        rst_n = 1'b1;

        // contention: grants alternate from req0 after reset
        exp_g = 2'd0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("cont_grant", 32'(bus.req_ready), 32'(2'b01 << exp_g));
            if (c > 0) check("cont_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            tick();
            ca = 32'h1000 + c;
            cb = 32'(c * 3);
            set_req(int'(exp_g), ALU_ADD, ca, cb, 4'(c + 4), ca + cb,
                    1'b0, "cont");
            exp_g = exp_g ^ 2'd1;
        end

        // backpressure: slot holds req1's op, nothing accepted
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_ready", 32'(bus.req_ready), 32'h0);
            check("bp_valid", 32'(bus.rsp_valid), 32'h1);
            check("bp_id", 32'(bus.rsp_id), 32'h1);
            check("bp_q_depth", sb_q.size(), 32'd1);
            if (sb_q.size() > 0) begin
                check("bp_result", bus.rsp_result, sb_q[0].res);
                check("bp_tag", 32'(bus.rsp_tag), 32'(sb_q[0].tag));
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_accept", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        check("bp_refill_valid", 32'(bus.rsp_valid), 32'h1);
        check("bp_refill_id", 32'(bus.rsp_id), 32'h0);
        tick();
        @(negedge clk);
        check("bp_empty", 32'(bus.rsp_valid), 32'h0);

        // op table, back to back through req0
        for (int i = 0; i < 12; i++) begin
            set_req(0, vecs[i].op, vecs[i].a, vecs[i].b, 4'(i),
                    vecs[i].res, vecs[i].zero, vecs[i].nm);
            bus.req_valid = 2'b01;
            @(negedge clk);
            check({"op_ready ", vecs[i].nm}, 32'(bus.req_ready), 32'h1);
            tick();
        end
        bus.req_valid = '0;
        tick();

        // fairness: req1 alone, then both -> req0 first
        for (int i = 0; i < 3; i++) begin
            set_req(1, ALU_ADD, 32'(i), 32'd100, 4'(i + 8),
                    32'(i + 100), 1'b0, "fair_r1");
            bus.req_valid = 2'b10;
            @(negedge clk);
            check("fair_r1_grant", 32'(bus.req_ready), 32'h2);
            tick();
        end
        set_req(0, ALU_OR, 32'h5, 32'hA, 4'd7, 32'hF, 1'b0, "fair_r0");
        bus.req_valid = 2'b11;
        @(negedge clk);
        check("fair_wrap_r0", 32'(bus.req_ready), 32'h1);
        tick();
        @(negedge clk);
        check("fair_next_r1", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        @(negedge clk);
        check("final_empty", 32'(bus.rsp_valid), 32'h0);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
